led_seq_ctrl: RTL and testbench
===============================

// Module: led_seq_ctrl
// PURPOSE
//   Sequencer for the 4-LED ring + centre LED. Owns the step-rate divider and
//   the pattern register; accepts mode/speed commands over a valid/ready port
//   so a button debouncer or UART decoder can change the display at runtime.
//   Sits between the command source and the D1..D5 LED pins in top.
// PARAMETERS
//   STEP_CYCLES  12000000  clk cycles per pattern step at speed 0 (1 s @ 12 MHz)
//   CNT_W        24        divider width; must hold STEP_CYCLES-1
// PORTS
//   clk        in   1   system clock (12 MHz)
//   rst        in   1   synchronous, active-high reset
//   cmd_valid  in   1   command present
//   cmd_ready  out  1   block can accept command this cycle
//   cmd_mode   in   2   0=STOP 1=ROT_L 2=ROT_R 3=BOUNCE
//   cmd_speed  in   2   step period = STEP_CYCLES >> cmd_speed
//   leds       out  4   pattern; leds[0]->D4, [1]->D3, [2]->D2, [3]->D1
//   led_run    out  1   D5; 1 when mode != STOP
//   step       out  1   1-cycle pulse on every pattern advance
// BEHAVIOUR
// - Reset (rst=1 at posedge): leds=4'b0001, mode=ROT_L, speed=0, dir=left,
//   divider=0, state=RUN, cmd_ready=1, led_run=1, step=0. Overrides everything.
// - States: RUN, APPLY. RUN: cmd_ready=1. Handshake = cmd_valid & cmd_ready;
//   on handshake latch mode/speed, go APPLY. APPLY (exactly 1 cycle):
//   cmd_ready=0, divider<=0, leds<=4'b0001, dir<=left, step=0; -> RUN.
//   Commands arriving in APPLY are not accepted; source must hold cmd_valid.
// - Divider (RUN only): limit = (STEP_CYCLES >> speed) - 1. If mode==STOP,
//   divider holds at 0, leds hold, step=0. Else if divider==limit: divider<=0,
//   step<=1, pattern advances; else divider+1. First step after APPLY occurs
//   limit+1 cycles later (step asserted registered, same edge leds update).
// - Pattern advance: ROT_L leds<={leds[2:0],leds[3]}; ROT_R {leds[0],leds[3:1]}.
//   BOUNCE: shift per dir; at leds==1000 moving left, dir flips and next is
//   0100; at 0001 moving right, flips, next 0010. No wrap in BOUNCE.
// - Handshake on the same cycle as a divider terminal count: command wins;
//   no step pulse, pattern not advanced.
// - Same command re-issued still passes APPLY (pattern restarts at 0001).
// - leds is always one-hot; led_run = (mode != STOP), registered from mode.
// - Divider compare uses CNT_W-bit unsigned arithmetic; no overflow since
//   divider never exceeds limit.
// TESTING (STEP_CYCLES=8 in sim)
//   1 rst 1 cycle, no cmd -> leds 0001,0010,0100,1000,0001 with step every
//     8 cycles; led_run=1, cmd_ready=1.
//   2 cmd mode=2 speed=1 -> cmd_ready=0 one cycle, leds=0001, then step every
//     4 cycles: 1000,0100,0010,0001.
//   3 cmd mode=3 speed=3 -> step every cycle, leds 0001,0010,0100,1000,0100,
//     0010,0001,0010 (no wrap).
//   4 cmd mode=0 -> led_run=0, leds frozen at 0001, step never asserts for
//     100 cycles; then cmd mode=1 resumes from 0001 after 8 cycles.
//   5 cmd_valid held through APPLY plus cmd on divider terminal cycle ->
//     exactly one acceptance per handshake, no step that cycle.
//   6 rst asserted mid-BOUNCE (leds=0100, dir=right) -> next cycle leds=0001,
//     mode=ROT_L, divider=0, cmd_ready=1.

Source files
------------

// File: rtl/led_seq_ctrl.sv
// ---------------------------------------------------------------------------
// led_seq_ctrl
// Pattern sequencer for the 4-LED ring plus the centre "run" LED. A step-rate
// divider advances a one-hot pattern according to the current mode. Mode and
// speed changes arrive over a valid/ready command port. Every accepted command
// passes through a one-cycle APPLY state that restarts the pattern.
//
// Parameters
//   STEP_CYCLES : clk cycles per pattern step at speed 0
//   CNT_W       : divider width, must hold STEP_CYCLES-1
//
// Ports
//   clk        in   1  system clock
//   rst        in   1  synchronous active-high reset
//   cmd_valid  in   1  command present
//   cmd_ready  out  1  command can be accepted this cycle (registered)
//   cmd_mode   in   2  0=STOP 1=ROT_L 2=ROT_R 3=BOUNCE
//   cmd_speed  in   2  step period = STEP_CYCLES >> cmd_speed
//   leds       out  4  one-hot pattern (registered)
//   led_run    out  1  1 while mode != STOP (registered)
//   step       out  1  one-cycle pulse on every pattern advance (registered)
// ---------------------------------------------------------------------------
module led_seq_ctrl #(
    parameter int unsigned STEP_CYCLES = 12000000,
    parameter int unsigned CNT_W       = 24
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_mode,
    input  logic [1:0] cmd_speed,
    output logic [3:0] leds,
    output logic       led_run,
    output logic       step
);

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_APPLY = 1'b1
    } state_t;

    localparam logic [1:0] MODE_STOP   = 2'd0;
    localparam logic [1:0] MODE_ROT_L  = 2'd1;
    localparam logic [1:0] MODE_ROT_R  = 2'd2;
    localparam logic [1:0] MODE_BOUNCE = 2'd3;

    // dir_r: 1'b0 = moving left (towards leds[3]), 1'b1 = moving right
    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    localparam logic [CNT_W-1:0] STEP_W  = CNT_W'(STEP_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // Next {dir, pattern} for one step of the given mode.
    function automatic logic [4:0] advance(input logic [1:0] mode,
                                           input logic       dir,
                                           input logic [3:0] pat);
        logic [4:0] res;
        res = {dir, pat};
        case (mode)
            MODE_ROT_L:  res = {dir, pat[2:0], pat[3]};
            MODE_ROT_R:  res = {dir, pat[0], pat[3:1]};
            MODE_BOUNCE: begin
                // End positions reflect instead of wrapping.
                if (dir == DIR_LEFT) begin
                    if (pat == 4'b1000) begin
                        res = {DIR_RIGHT, 4'b0100};
                    end else begin
                        res = {DIR_LEFT, pat[2:0], 1'b0};
                    end
                end else begin
                    if (pat == 4'b0001) begin
                        res = {DIR_LEFT, 4'b0010};
                    end else begin
                        res = {DIR_RIGHT, 1'b0, pat[3:1]};
                    end
                end
            end
            default:     res = {dir, pat};
        endcase
        return res;
    endfunction

    state_t           state_r, state_nxt_s;
    logic [1:0]       mode_r, mode_nxt_s;
    logic [1:0]       speed_r, speed_nxt_s;
    logic             dir_r, dir_nxt_s;
    logic [CNT_W-1:0] div_r, div_nxt_s;
    logic [3:0]       leds_r, leds_nxt_s;
    logic             step_r, step_nxt_s;
    logic             cmd_ready_r;
    logic             led_run_r;
    logic             hs_s;
    logic [CNT_W-1:0] limit_s;
    logic [4:0]       adv_s;

    assign hs_s    = cmd_valid & cmd_ready_r;
    assign limit_s = (STEP_W >> speed_r) - CNT_ONE;
    assign adv_s   = advance(mode_r, dir_r, leds_r);

    assign cmd_ready = cmd_ready_r;
    assign leds      = leds_r;
    assign led_run   = led_run_r;
    assign step      = step_r;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_RUN;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic: a handshake in RUN enters APPLY for exactly one cycle.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_RUN: begin
                if (hs_s) begin
                    state_nxt_s = ST_APPLY;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_APPLY: state_nxt_s = ST_RUN;
            default:  state_nxt_s = ST_RUN;
        endcase
    end

    // Output/datapath next values: command latch, divider and pattern advance.
    always_comb begin
        mode_nxt_s  = mode_r;
        speed_nxt_s = speed_r;
        dir_nxt_s   = dir_r;
        div_nxt_s   = div_r;
        leds_nxt_s  = leds_r;
        step_nxt_s  = 1'b0;
        case (state_r)
            ST_RUN: begin
                if (hs_s) begin
                    // A command beats a coincident terminal count.
                    mode_nxt_s  = cmd_mode;
                    speed_nxt_s = cmd_speed;
                end else if (mode_r == MODE_STOP) begin
                    div_nxt_s = '0;
                end else if (div_r == limit_s) begin
                    div_nxt_s  = '0;
                    step_nxt_s = 1'b1;
                    dir_nxt_s  = adv_s[4];
                    leds_nxt_s = adv_s[3:0];
                end else begin
                    div_nxt_s = div_r + CNT_ONE;
                end
            end
            ST_APPLY: begin
                div_nxt_s  = '0;
                leds_nxt_s = 4'b0001;
                dir_nxt_s  = DIR_LEFT;
            end
            default: begin
                div_nxt_s  = '0;
                leds_nxt_s = 4'b0001;
                dir_nxt_s  = DIR_LEFT;
            end
        endcase
    end

    // Datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_r      <= MODE_ROT_L;
            speed_r     <= 2'd0;
            dir_r       <= DIR_LEFT;
            div_r       <= '0;
            leds_r      <= 4'b0001;
            step_r      <= 1'b0;
            cmd_ready_r <= 1'b1;
            led_run_r   <= 1'b1;
        end else begin
            mode_r      <= mode_nxt_s;
            speed_r     <= speed_nxt_s;
            dir_r       <= dir_nxt_s;
            div_r       <= div_nxt_s;
            leds_r      <= leds_nxt_s;
            step_r      <= step_nxt_s;
            cmd_ready_r <= (state_nxt_s == ST_RUN);
            led_run_r   <= (mode_nxt_s != MODE_STOP);
        end
    end

endmodule

// File: tb/tb_led_seq_ctrl.sv
module tb_led_seq_ctrl;

    localparam int STEP = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_mode = 2'd0;
    logic [1:0] cmd_speed = 2'd0;
    logic [3:0] leds;
    logic       led_run;
    logic       step;

    typedef struct {
        logic [3:0] leds;
        int         gap;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   cnt = -1;
    bit   done = 1'b0;

    led_seq_ctrl #(.STEP_CYCLES(STEP), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_mode(cmd_mode), .cmd_speed(cmd_speed), .leds(leds),
        .led_run(led_run), .step(step)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int got, input int want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, want, $time);
        end
    endtask

    task automatic push(input logic [3:0] l, input int gap);
        exp_t e;
        e.leds = l;
        e.gap  = gap;
        exp_q.push_back(e);
    endtask

    // Monitor: each step pulse is matched against the next expected pattern
    // and the number of clock edges since the previous step/restart.
    always @(negedge clk) begin
        if (!done) begin
            cnt++;
            if (step === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_step: leds=%b at %0t", leds, $time);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("step_leds", int'(leds), int'(e.leds));
                    check("step_gap", cnt, e.gap);
                end
                cnt = 0;
            end
            if (rst === 1'b1 || cmd_ready !== 1'b1) cnt = -1;
        end
    end

    // Drive one command and hold it until the handshake edge.
    task automatic issue(input logic [1:0] m, input logic [1:0] s);
        bit ok;
        ok = 1'b0;
        cmd_mode  = m;
        cmd_speed = s;
        cmd_valid = 1'b1;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (cmd_ready === 1'b1) begin
                @(posedge clk);
                #1;
                ok = 1'b1;
            end
        end
        cmd_valid = 1'b0;
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL handshake_timeout: mode=%0d", m);
        end
    endtask

    task automatic wait_empty(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            #2;
            if (exp_q.size() == 0) ok = 1'b1;
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout: %0d steps missing", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        int hs;
        // 1: reset, free-running ROT_L at speed 0
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        push(4'b0010, 8); push(4'b0100, 8); push(4'b1000, 8); push(4'b0001, 8);
        @(negedge clk);
        check("rst_leds", int'(leds), 1);
        check("rst_ready", int'(cmd_ready), 1);
        check("rst_run", int'(led_run), 1);
        check("rst_step", int'(step), 0);
        wait_empty("t1");

        // 2: ROT_R speed 1
        push(4'b1000, 4); push(4'b0100, 4); push(4'b0010, 4); push(4'b0001, 4);
        issue(2'd2, 2'd1);
        @(negedge clk);
        check("t2_apply_ready", int'(cmd_ready), 0);
        @(negedge clk);
        check("t2_ready", int'(cmd_ready), 1);
        check("t2_leds", int'(leds), 1);
        wait_empty("t2");

        // 3: BOUNCE speed 3, then STOP on a terminal-count cycle
        push(4'b0010, 1); push(4'b0100, 1); push(4'b1000, 1); push(4'b0100, 1);
        push(4'b0010, 1); push(4'b0001, 1); push(4'b0010, 1);
        issue(2'd3, 2'd3);
        repeat (8) @(posedge clk);
        #1;
        issue(2'd0, 2'd0);
        check("t3_all_steps", exp_q.size(), 0);

        // 4: STOP freezes the pattern, then ROT_L resumes from 0001
        @(negedge clk);
        check("t4_apply_ready", int'(cmd_ready), 0);
        check("t4_run_off", int'(led_run), 0);
        repeat (100) @(negedge clk);
        check("t4_leds_frozen", int'(leds), 1);
        check("t4_run_still_off", int'(led_run), 0);
        check("t4_ready", int'(cmd_ready), 1);
        push(4'b0010, 8);
        issue(2'd1, 2'd0);
        @(negedge clk);
        check("t4_run_on", int'(led_run), 1);
        wait_empty("t4");

        // 5: cmd_valid held through APPLY, first handshake on terminal count
        repeat (7) @(posedge clk);
        #1;
        cmd_mode  = 2'd2;
        cmd_speed = 2'd0;
        cmd_valid = 1'b1;
        hs = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (cmd_ready === 1'b1) hs++;
        end
        cmd_valid = 1'b0;
        check("t5_accepts", hs, 2);
        push(4'b1000, 8);
        wait_empty("t5");

        // 6: reset in the middle of a BOUNCE sweep (0100 moving right)
        push(4'b0010, 1); push(4'b0100, 1); push(4'b1000, 1); push(4'b0100, 1);
        issue(2'd3, 2'd3);
        repeat (5) @(posedge clk);
        #1;
        check("t6_pre_leds", int'(leds), 4);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        check("t6_pending", exp_q.size(), 0);
        push(4'b0010, 8);
        @(negedge clk);
        check("t6_leds", int'(leds), 1);
        check("t6_ready", int'(cmd_ready), 1);
        check("t6_run", int'(led_run), 1);
        check("t6_step", int'(step), 0);
        wait_empty("t6");

        repeat (3) @(negedge clk);
        done = 1'b1;
        check("final_queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
